// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer: releases three active-low resets in order, gating each on the previous stage's ack,
// and replays the sequence (reverse shutdown first when running) on a soft-reset request.
module reset_release_sequencer #(
    parameter int MIN_HOLD = 1024,
    parameter int TIMEOUT  = 2097152
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iREQ_RST,
    input  logic       iACK_0,
    input  logic       iACK_1,
    input  logic       iACK_2,
    output logic       oRST_0,
    output logic       oRST_1,
    output logic       oRST_2,
    output logic       oREADY,
    output logic [1:0] oSTAGE,
    output logic [2:0] oERR
);
    localparam logic [31:0] HOLD_LAST = 32'(MIN_HOLD - 1);
    localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [3:0] {HOLD0, WAIT0, HOLD1, WAIT1, HOLD2, WAIT2, RUN, SHUT2, SHUT1, SHUT0} state_t;

    state_t      state, nState, holdNext, waitNext;
    logic [31:0] cnt, nCnt;
    logic [2:0]  rstOut, nRst, err, nErr, ack;
    logic [1:0]  stage, nStage, idx;
    logic        ready, nReady, restart;

    assign ack = {iACK_2, iACK_1, iACK_0};
    assign idx = (state == HOLD2 || state == WAIT2) ? 2'd2 : (state == HOLD1 || state == WAIT1) ? 2'd1 : 2'd0;
    assign holdNext = (idx == 2'd2) ? WAIT2 : (idx == 2'd1) ? WAIT1 : WAIT0;
    assign waitNext = (idx == 2'd2) ? RUN : (idx == 2'd1) ? HOLD2 : HOLD1;

    always_comb begin
        nState  = state;
        nRst    = rstOut;
        nReady  = ready;
        nStage  = stage;
        nErr    = err;
        restart = 1'b0;
        case (state)
            HOLD0, HOLD1, HOLD2, WAIT0, WAIT1, WAIT2: begin
                if (iREQ_RST) begin
                    // a request mid bring-up drops every stage and restarts the hold
                    restart = 1'b1;
                    nState  = HOLD0;
                    nRst    = 3'b000;
                    nStage  = 2'd0;
                end else if ((state == HOLD0 || state == HOLD1 || state == HOLD2) && cnt == HOLD_LAST) begin
                    nRst[idx] = 1'b1;
                    nStage    = idx + 2'd1;
                    nState    = holdNext;
                end else if ((state == WAIT0 || state == WAIT1 || state == WAIT2) && (ack[idx] || cnt == WAIT_LAST)) begin
                    nErr[idx] = err[idx] | ~ack[idx];
                    nReady    = (waitNext == RUN);
                    nState    = waitNext;
                end
            end
            RUN: if (iREQ_RST) begin
                nState = SHUT2;
                nReady = 1'b0;
                nRst   = 3'b011;
                nStage = 2'd2;
            end
            SHUT2: begin
                nState = SHUT1;
                nRst   = 3'b001;
                nStage = 2'd1;
            end
            SHUT1: begin
                nState = SHUT0;
                nRst   = 3'b000;
                nStage = 2'd0;
            end
            default: nState = HOLD0;
        endcase
        nCnt = (nState != state || restart) ? 32'd0 : cnt + 32'd1;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state  <= HOLD0;
            cnt    <= 32'd0;
            rstOut <= 3'b000;
            ready  <= 1'b0;
            stage  <= 2'd0;
            err    <= 3'b000;
        end else begin
            state  <= nState;
            cnt    <= nCnt;
            rstOut <= nRst;
            ready  <= nReady;
            stage  <= nStage;
            err    <= nErr;
        end
    end

    assign oRST_0 = rstOut[0];
    assign oRST_1 = rstOut[1];
    assign oRST_2 = rstOut[2];
    assign oREADY = ready;
    assign oSTAGE = stage;
    assign oERR   = err;
endmodule

// File: tb/tb_reset_release_sequencer.sv
// tb_reset_release_sequencer: checks every cycle against a timeline model that derives release,
// advance and timeout edges arithmetically from the ack delays the bench chooses.
module tb_reset_release_sequencer;
    localparam int MH = 4;
    localparam int TO = 16;

    logic       iCLK = 1'b0, iRST = 1'b0, iREQ_RST = 1'b0;
    logic       iACK_0 = 1'b0, iACK_1 = 1'b0, iACK_2 = 1'b0;
    logic       oRST_0, oRST_1, oRST_2, oREADY;
    logic [1:0] oSTAGE;
    logic [2:0] oERR;

    int tests = 0, fails = 0;
    int ec, shut;
    int rel[3], adv[3], a[3];
    bit to[3];
    bit randA;
    logic [2:0] errBase;

    reset_release_sequencer #(.MIN_HOLD(MH), .TIMEOUT(TO)) dut (
        .iCLK(iCLK), .iRST(iRST), .iREQ_RST(iREQ_RST),
        .iACK_0(iACK_0), .iACK_1(iACK_1), .iACK_2(iACK_2),
        .oRST_0(oRST_0), .oRST_1(oRST_1), .oRST_2(oRST_2),
        .oREADY(oREADY), .oSTAGE(oSTAGE), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, ec);
        end
    endtask

    // bring-up starting in HOLD0 with a cleared counter after edge b
    function automatic void plan(int b);
        int t;
        t = b;
        for (int n = 0; n < 3; n++) begin
            rel[n] = t + MH;
            to[n]  = a[n] > TO;
            adv[n] = rel[n] + (to[n] ? TO : a[n]);
            t      = adv[n];
        end
    endfunction

    task automatic checkAll();
        logic [2:0] r, e;
        bit inShut;
        inShut = shut >= 0 && ec >= shut && ec <= shut + 2;
        for (int n = 0; n < 3; n++) begin
            r[n] = ec >= rel[n];
            e[n] = errBase[n] | (to[n] && ec >= adv[n]);
        end
        if (inShut) r = 3'b011 >> (ec - shut);
        chk("rst", {29'd0, oRST_2, oRST_1, oRST_0}, {29'd0, r});
        chk("stage", {30'd0, oSTAGE}, 32'(int'(r[0]) + int'(r[1]) + int'(r[2])));
        chk("ready", {31'd0, oREADY}, {31'd0, !inShut && ec >= adv[2]});
        chk("err", {29'd0, oERR}, {29'd0, e});
    endtask

    task automatic step(bit req);
        bit run;
        if (req && !(shut >= 0 && ec >= shut && ec <= shut + 2)) begin
            run = ec >= adv[2];
            for (int n = 0; n < 3; n++) if (adv[n] <= ec) errBase[n] = errBase[n] | to[n];
            if (randA) for (int n = 0; n < 3; n++) a[n] = $urandom_range(1, TO + 3);
            if (run) begin
                shut = ec + 1;
                plan(ec + 4);
            end else plan(ec + 1);
        end
        iREQ_RST = req;
        iACK_0 = ec + 1 >= rel[0] + a[0];
        iACK_1 = ec + 1 >= rel[1] + a[1];
        iACK_2 = ec + 1 >= rel[2] + a[2];
        @(posedge iCLK);
        ec++;
        #1 checkAll();
    endtask

    task automatic runTo(int e);
        while (ec < e) step(1'b0);
    endtask

    initial begin
        shut = -1; errBase = 3'b000; randA = 1'b0; ec = 0;
        a = '{2, 2, 2};
        plan(0);
        repeat (3) @(posedge iCLK);
        #1 checkAll();
        iRST = 1'b1;
        runTo(adv[2] + 3);
        a = '{2, 1000, 2};
        step(1'b1);
        runTo(adv[2] + 3);
        a = '{2, 2, 2};
        step(1'b1);
        runTo(adv[2] + 3);
        a = '{1, 2, TO};
        step(1'b1);
        runTo(rel[1] + 1);
        step(1'b1);
        runTo(adv[2] + 2);
        repeat (8) step(1'b1);
        runTo(adv[2] + 3);
        randA = 1'b1;
        repeat (400) step($urandom_range(0, 30) == 0);
        randA = 1'b0;
        runTo(adv[2] + 2);
        #3 iRST = 1'b0;
        #1 chk("async_rst", {24'd0, oREADY, oSTAGE, oERR, oRST_2, oRST_1, oRST_0}, 32'd0);
        iREQ_RST = 1'b0; iACK_0 = 1'b0; iACK_1 = 1'b0; iACK_2 = 1'b0;
        @(negedge iCLK);
        chk("held_rst", {24'd0, oREADY, oSTAGE, oERR, oRST_2, oRST_1, oRST_0}, 32'd0);
        errBase = 3'b000; shut = -1; ec = 0;
        a = '{3, 1, 5};
        plan(0);
        iRST = 1'b1;
        runTo(adv[2] + 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
